bch_encoder_p8: RTL and testbench

BCH_ENCODER_P8 -- requirements
Module: bch_encoder_p8

---
 rtl/bch_enc_pkg.sv | 62 ++++++
 rtl/bch_enc_lfsr_step.sv | 30 +++
 rtl/bch_encoder_p8.sv | 115 +++++++++++
 tb/tb_bch_encoder_p8.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_enc_pkg.sv
// ---------------------------------------------------------------------------
// bch_enc_pkg
// Shared constants for the binary BCH(8191-derived, m=13, t=8) encoder:
//   M, T       field degree and correction capability
//   R          parity bits (M*T = 104)
//   P, K       default beat width and message bits per frame
//   PRIM_POLY  primitive polynomial of GF(2^13): x^13+x^4+x^3+x+1
//   G_POLY     generator polynomial, degree R, coefficient i at bit i
//   state_t    encoder FSM states
// G_POLY is built at elaboration time as the product of (x + alpha^e) over
// the conjugacy classes of alpha^1, alpha^3, ..., alpha^(2T-1).
// ---------------------------------------------------------------------------
package bch_enc_pkg;

   localparam int M = 13;
   localparam int T = 8;
   localparam int R = M * T;
   localparam int P = 8;
   localparam int K = 1024;

   localparam logic [M:0] PRIM_POLY = 14'h201B;

   typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;

   // GF(2^M) multiply, polynomial basis, reduced by PRIM_POLY
   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [M-1:0] r;
      r = '0;
      for (int i = M - 1; i >= 0; i--) begin
         r = {r[M-2:0], 1'b0} ^ (r[M-1] ? PRIM_POLY[M-1:0] : '0);
         if (b[i]) r = r ^ a;
      end
      return r;
   endfunction

   // Product of all R roots; the GF(2^M) coefficients collapse to 0/1
   function automatic logic [R:0] gen_poly();
      logic [M-1:0] c [0:R];
      logic [M-1:0] a;
      logic [R:0]   g;
      int           deg;
      for (int d = 0; d <= R; d++) c[d] = '0;
      c[0] = M'(1);
      deg  = 0;
      for (int i = 1; i < 2 * T; i += 2) begin
         a = M'(1);
         for (int s = 0; s < i; s++) a = gf_mul(a, M'(2));
         // walk the conjugates a, a^2, a^4, ...
         for (int s = 0; s < M; s++) begin
            for (int d = deg + 1; d >= 1; d--) c[d] = c[d-1] ^ gf_mul(c[d], a);
            c[0] = gf_mul(c[0], a);
            deg++;
            a = gf_mul(a, a);
         end
      end
      for (int d = 0; d <= R; d++) g[d] = c[d][0];
      return g;
   endfunction

   localparam logic [R:0] G_POLY = gen_poly();

endpackage

// File: rtl/bch_enc_lfsr_step.sv
// ---------------------------------------------------------------------------
// bch_enc_lfsr_step
// Combinational P-bit advance of the systematic-encoder remainder register.
// Equivalent to P serial LFSR clocks, din[P-1] consumed first.
//   rem_in   current remainder (R bits)
//   din      P message bits, bit P-1 highest degree
//   rem_out  remainder after the P steps
// ---------------------------------------------------------------------------
module bch_enc_lfsr_step
   import bch_enc_pkg::*;
#(
   parameter int P = bch_enc_pkg::P
) (
   input  logic [R-1:0] rem_in,
   input  logic [P-1:0] din,
   output logic [R-1:0] rem_out
);

   logic fb;

   always_comb begin
      rem_out = rem_in;
      fb      = 1'b0;
      for (int i = P - 1; i >= 0; i--) begin
         fb      = rem_out[R-1] ^ din[i];
         rem_out = {rem_out[R-2:0], 1'b0} ^ ({R{fb}} & G_POLY[R-1:0]);
      end
   end

endmodule

// File: rtl/bch_encoder_p8.sv
// ---------------------------------------------------------------------------
// bch_encoder_p8
// Streaming systematic BCH encoder, P bits per beat. Passes K/P message
// beats through a registered output stage, then emits R/P parity beats.
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     message beat handshake, in_data[P-1] highest degree
//   out_valid/out_ready   codeword beat handshake, out_data[P-1] sent first
//   out_parity            beat carries parity
//   out_last              final parity beat of the codeword
// ---------------------------------------------------------------------------
module bch_encoder_p8
   import bch_enc_pkg::*;
#(
   parameter int P = bch_enc_pkg::P,
   parameter int K = bch_enc_pkg::K
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [P-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [P-1:0] out_data,
   output logic         out_parity,
   output logic         out_last
);

   localparam int KB = K / P;
   localparam int RB = R / P;
   localparam int CW = $clog2(((KB > RB) ? KB : RB) + 1);

   state_t         state, state_nx;
   logic [CW-1:0]  cnt;
   logic [R-1:0]   lfsr, lfsr_nx, par_sr;
   logic           out_free, take_in, take_out, last_msg, last_par, par_load;

   bch_enc_lfsr_step #(.P(P)) u_step (
      .rem_in  (lfsr),
      .din     (in_data),
      .rem_out (lfsr_nx)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // next state
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, MSG: if (take_in) state_nx = last_msg ? PAR : MSG;
         PAR:       if (take_out && out_last) state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   // handshake / control strobes
   always_comb begin
      out_free = !out_valid || out_ready;
      in_ready = (state != PAR) && out_free;
      take_in  = in_valid && in_ready;
      take_out = out_valid && out_ready;
      last_msg = (cnt == CW'(KB - 1));
      last_par = (cnt == CW'(RB - 1));
      // once the final parity beat sits in the output stage, stop loading
      par_load = (state == PAR) && out_free && !(out_valid && out_last);
   end

   // beat counter: message beats accepted in MSG, parity beats loaded in PAR
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        cnt <= '0;
      else if (take_in)  cnt <= last_msg ? '0 : cnt + CW'(1);
      else if (par_load) cnt <= last_par ? '0 : cnt + CW'(1);
   end

   // remainder and parity shift register; the LFSR is cleared as its final
   // value moves into par_sr, so the next frame starts from zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr   <= '0;
         par_sr <= '0;
      end else if (take_in) begin
         lfsr <= last_msg ? '0 : lfsr_nx;
         if (last_msg) par_sr <= lfsr_nx;
      end else if (par_load) begin
         par_sr <= {par_sr[R-P-1:0], {P{1'b0}}};
      end
   end

   // registered output stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_parity <= 1'b0;
         out_last   <= 1'b0;
      end else if (take_in) begin
         out_valid  <= 1'b1;
         out_data   <= in_data;
         out_parity <= 1'b0;
         out_last   <= 1'b0;
      end else if (par_load) begin
         out_valid  <= 1'b1;
         out_data   <= par_sr[R-1 -: P];
         out_parity <= 1'b1;
         out_last   <= last_par;
      end else if (take_out) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bch_encoder_p8.sv
`timescale 1ns/1ps
module tb_bch_encoder_p8;
   import bch_enc_pkg::*;

   localparam int KB = K / P;
   localparam int RB = R / P;
   localparam int N  = K + R;

   typedef struct packed {
      logic [P-1:0] d;
      logic         par;
      logic         last;
   } beat_t;

   logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_parity, out_last;
   logic [P-1:0] in_data, out_data;

   bch_encoder_p8 #(.P(P), .K(K)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_parity (out_parity),
      .out_last   (out_last)
   );

   beat_t        sb[$];
   int           nvec = 0, nerr = 0, cyc = 0;
   bit           msg [0:K-1];
   bit           rdy_rand = 0;
   int           frame_beat = 0, last_take_cyc = -100, gap_meas = -1;
   logic         ir_after_last = 0, ir_meas = 0;
   logic [N-1:0] obs_cw = '0;
   logic [R-1:0] obs_par = '0;
   logic         prev_v = 0, prev_r = 0;
   beat_t        prev_beat, e;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [M-1:0] tb_gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [M-1:0] r = '0;
      for (int i = M - 1; i >= 0; i--) begin
         r = {r[M-2:0], 1'b0} ^ (r[M-1] ? 13'h001B : 13'h0);
         if (b[i]) r = r ^ a;
      end
      return r;
   endfunction

   // number of nonzero syndromes S1..S2T of c(x), bit i = coefficient of x^i
   function automatic int syn_bad(input logic [N-1:0] c);
      logic [M-1:0] a, s;
      int bad = 0;
      for (int j = 1; j <= 2 * T; j++) begin
         a = 13'h1;
         for (int k = 0; k < j; k++) a = tb_gf_mul(a, 13'h2);
         s = '0;
         for (int d = N - 1; d >= 0; d--) s = tb_gf_mul(s, a) ^ {12'b0, c[d]};
         if (s != '0) bad++;
      end
      return bad;
   endfunction

   // long division of m(x)*x^R by g(x)
   function automatic logic [R-1:0] model_par();
      logic [N-1:0] dv = '0;
      for (int i = 0; i < K; i++) dv[N-1-i] = msg[i];
      for (int deg = N - 1; deg >= R; deg--)
         if (dv[deg])
            for (int k = 0; k <= R; k++) dv[deg-R+k] = dv[deg-R+k] ^ G_POLY[k];
      return dv[R-1:0];
   endfunction

   task automatic fill_msg(input int mode);
      for (int i = 0; i < K; i++)
         msg[i] = (mode == 2) ? 1'($urandom_range(0, 1)) : ((mode == 1) && (i == K - 1));
   endtask

   // drive nbeats message beats; parity expectations go in when the last one is accepted
   task automatic send_frame(input int nbeats, input bit gaps);
      logic [R-1:0] ep;
      int tmo;
      ep = model_par();
      for (int b = 0; b < nbeats; b++) begin
         for (int j = 0; j < P; j++) in_data[P-1-j] = msg[b*P+j];
         while (gaps && ($urandom_range(0, 1) == 1)) begin
            in_valid = 0;
            @(posedge clk); #1;
         end
         in_valid = 1;
         tmo = 0;
         forever begin
            @(negedge clk);
            if (in_ready) break;
            tmo++;
            if (tmo > 2000) break;
         end
         if (tmo > 2000) begin
            chk("accept_timeout", tmo, 0);
            in_valid = 0;
            return;
         end
         sb.push_back(beat_t'{d: in_data, par: 1'b0, last: 1'b0});
         if (b == KB - 1)
            for (int p = 0; p < RB; p++)
               sb.push_back(beat_t'{d: ep[R-1-p*P -: P], par: 1'b1, last: (p == RB - 1)});
         @(posedge clk); #1;
      end
      in_valid = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < 5000 && sb.size() != 0; i++) @(posedge clk);
      chk("drain", sb.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // downstream ready: always high or 50% random
   initial begin
      out_ready = 1;
      forever begin
         @(posedge clk); #1;
         out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // scoreboard pop, stall-hold and framing checks
   always @(negedge clk) begin
      if (!rst_n) begin
         frame_beat = 0;
         prev_v     = 0;
      end else begin
         if (prev_v && !prev_r) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_beat", {out_data, out_parity, out_last}, prev_beat);
         end
         if (cyc == last_take_cyc + 1) ir_after_last = in_ready;
         if (out_valid && out_ready) begin
            if (frame_beat == 0) begin
               gap_meas = cyc - last_take_cyc;
               ir_meas  = ir_after_last;
            end
            if (sb.size() == 0) chk("unexpected_beat", {out_data, out_parity, out_last}, 'x);
            else begin
               e = sb.pop_front();
               chk("beat", {out_data, out_parity, out_last}, e);
            end
            if (frame_beat < KB + RB) obs_cw[N-1-frame_beat*P -: P] = out_data;
            if (out_parity) obs_par = {obs_par[R-P-1:0], out_data};
            if (out_last) begin
               chk("last_index", frame_beat + 1, KB + RB);
               frame_beat    = 0;
               last_take_cyc = cyc;
            end else frame_beat++;
         end
         prev_v    = out_valid;
         prev_r    = out_ready;
         prev_beat = {out_data, out_parity, out_last};
      end
   end

   initial begin
      rst_n = 0; in_valid = 0; in_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_parity", out_parity, 0);
      chk("rst_out_last", out_last, 0);
      @(posedge clk); #1;
      rst_n = 1;
      @(negedge clk);
      chk("in_ready_after_rst", in_ready, 1);
      chk("gpoly_ends", {G_POLY[R], G_POLY[0]}, 2'b11);
      chk("gpoly_roots", syn_bad(N'(G_POLY)), 0);
      @(posedge clk); #1;

      // all-zero message
      fill_msg(0); send_frame(KB, 0); drain();
      chk("zero_parity", obs_par, 0);

      // m(x) = 1: remainder of x^R mod g is g without its top term
      fill_msg(1); send_frame(KB, 0); drain();
      chk("par_eq_g", obs_par, G_POLY[R-1:0]);

      // random message, full codeword must be divisible by g
      fill_msg(2); send_frame(KB, 0); drain();
      chk("syndromes_rand", syn_bad(obs_cw), 0);

      // random message with random input gaps and downstream stalls
      rdy_rand = 1;
      fill_msg(2); send_frame(KB, 1); drain();
      rdy_rand = 0;
      chk("syndromes_stall", syn_bad(obs_cw), 0);

      // reset mid-frame after 60 beats, then an all-zero frame
      fill_msg(2); send_frame(60, 0);
      rst_n = 0;
      sb.delete();
      @(negedge clk);
      chk("midrst_out_valid", out_valid, 0);
      @(posedge clk); #1;
      rst_n = 1;
      fill_msg(0); send_frame(KB, 0); drain();
      chk("midrst_zero_parity", obs_par, 0);

      // back-to-back frames: in_ready the cycle after out_last is taken,
      // next first beat accepted then and visible one registered cycle later
      fill_msg(2); send_frame(KB, 0);
      fill_msg(2); send_frame(KB, 0); drain();
      chk("b2b_in_ready", ir_meas, 1);
      chk("b2b_gap", gap_meas, 2);
      chk("syndromes_b2b", syn_bad(obs_cw), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
